mem_access_unit: RTL and testbench

- Load/store sequencer between the pipeline's MEM stage and the word-wide, byte-addressed little-endian data memory. The data memory has a combinational read, a synchronous write and a 12-bit address.
- Converts byte, halfword and word loads and stores into aligned word accesses:
  - Sub-word stores use a read-modify-write sequence.
  - Loads are extracted and sign- or zero-extended.
- Flags misaligned accesses and presents a busy/done handshake so the core can stall.

---
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 tb/tb_mem_access_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a word-wide, byte-addressed,
// little-endian data memory (combinational read, synchronous write).
// Sub-word stores use read-modify-write. Loads are lane-extracted and then
// sign- or zero-extended. Misaligned accesses are flagged.
// Optional feature: define MAU_RANGE_CHK_EN to fault addresses with any bit
// above ADDR_W-1 set. By default those bits are ignored and the address wraps.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic [31:0]       badvaddr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    input  logic [31:0]       dm_dout
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StFin} state_e;

    state_e            state_q, state_d;
    logic              is_store_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rbuf_q;
    logic [31:0]       rdata_q;
    logic [31:0]       badvaddr_q;
    logic              exc_q;

    logic              misaligned;
    logic              bad_range;
    logic              fault;
    logic [31:0]       lane_shifted;
    logic [31:0]       ld_val;
    logic [31:0]       merged;

    // Fault classification of the incoming request, used only at accept.
    always_comb begin
        misaligned = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`ifdef MAU_RANGE_CHK_EN
        bad_range = |addr[31:ADDR_W];
`else
        bad_range = 1'b0;
`endif
        fault = misaligned | bad_range;
    end

    // Load extraction from the live memory word; lanes are aligned by this point,
    // so a byte-granular shift serves both byte and half loads.
    always_comb begin
        lane_shifted = dm_dout >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'b00: ld_val = uns_q ? {24'b0, lane_shifted[7:0]}
                                  : {{24{lane_shifted[7]}}, lane_shifted[7:0]};
            2'b01: ld_val = uns_q ? {16'b0, lane_shifted[15:0]}
                                  : {{16{lane_shifted[15]}}, lane_shifted[15:0]};
            default: ld_val = dm_dout;
        endcase
    end

    // Store merge of the latched data into the word read back during RD.
    always_comb begin
        merged = rbuf_q;
        case (size_q)
            2'b00: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01: merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req) begin
                    if (fault) begin
                        state_d = StFin;
                    end else if (is_store && size[1]) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd:    state_d = is_store_q ? StWr : StFin;
            StWr:    state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register plus request latch, read buffer and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            is_store_q <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            rbuf_q     <= 32'h0;
            rdata_q    <= 32'h0;
            badvaddr_q <= 32'h0;
            exc_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == StIdle) && req) begin
                is_store_q <= is_store;
                size_q     <= size;
                uns_q      <= uns;
                addr_q     <= addr[ADDR_W-1:0];
                wdata_q    <= wdata;
                exc_q      <= fault;
                if (fault) begin
                    badvaddr_q <= addr;
                end
            end
            if (state_q == StRd) begin
                rbuf_q <= dm_dout;
                if (!is_store_q) begin
                    rdata_q <= ld_val;
                end
            end
        end
    end

    assign rdata    = rdata_q;
    assign badvaddr = badvaddr_q;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StFin);
    assign exc_adel = done & exc_q & ~is_store_q;
    assign exc_ades = done & exc_q & is_store_q;
    assign dm_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign dm_din   = merged;
    // Gated by reset so a reset edge during WR never commits a write.
    assign dm_we    = (state_q == StWr) & ~rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a latency/arithmetic model of each
// access is compared against the DUT every cycle, plus literal end results.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        is_store = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        exc_adel;
    logic        exc_ades;
    logic [31:0] badvaddr;
    logic [11:0] dm_addr;
    logic [31:0] dm_din;
    logic        dm_we;
    logic [31:0] dm_dout;

    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        load_mem = 1'b1;
    logic        chk_en = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int n_done = 0;

    // Model of the access in flight: cycle index since accept, total latency,
    // write cycle (0 = none) and the precomputed results.
    logic        m_active = 1'b0;
    int          m_c = 0;
    int          m_lat = 0;
    int          m_we_at = 0;
    logic        m_store = 1'b0;
    logic        m_mis = 1'b0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_ldval = 32'h0;
    logic [31:0] m_din = 32'h0;
    logic [31:0] m_rdata = 32'h0;
    logic [31:0] m_badv = 32'h0;

    mem_access_unit #(.ADDR_W(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .is_store (is_store),
        .size     (size),
        .uns      (uns),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done),
        .exc_adel (exc_adel),
        .exc_ades (exc_ades),
        .badvaddr (badvaddr),
        .dm_addr  (dm_addr),
        .dm_din   (dm_din),
        .dm_we    (dm_we),
        .dm_dout  (dm_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'h80FF_7F01;
        if (i == 8) return 32'h1122_3344;
        return 32'h0;
    endfunction

    function automatic logic m_fault(logic [1:0] sz, logic [31:0] a);
        logic f;
        f = ((sz == 2'd1) && a[0]) || ((sz >= 2'd2) && (a[1:0] != 2'b00));
`ifdef MAU_RANGE_CHK_EN
        f = f || (a[31:12] != 20'h0);
`endif
        return f;
    endfunction

    function automatic logic [31:0] m_load(logic [31:0] w, logic [31:0] a, logic [1:0] sz,
                                           logic u);
        logic [31:0] v;
        v = w >> (8 * a[1:0]);
        if (sz == 2'd0) begin
            v = v & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_merge(logic [31:0] w, logic [31:0] a, logic [1:0] sz,
                                            logic [31:0] d);
        logic [31:0] mask;
        if (sz >= 2'd2) return d;
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * a[1:0]);
        return (w & ~mask) | ((d << (8 * a[1:0])) & mask);
    endfunction

    assign dm_dout = mem[dm_addr[11:2]];

    // Environment memory: written only by the DUT's write strobe.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else if (dm_we) begin
            mem[dm_addr[11:2]] <= dm_din;
        end
    end

    // Reference model update.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 1024; i++) ref_mem[i] <= init_word(i);
        end else if (m_active && (m_c == m_we_at) && !rst) begin
            ref_mem[m_addr[11:2]] <= m_din;
        end
        if (rst) begin
            m_active <= 1'b0;
            m_rdata  <= 32'h0;
            m_badv   <= 32'h0;
        end else if (m_active) begin
            if (m_c == m_lat) begin
                m_active <= 1'b0;
            end else begin
                m_c <= m_c + 1;
                if ((m_c + 1 == m_lat) && !m_store && !m_mis) m_rdata <= m_ldval;
            end
        end else if (req) begin
            m_active <= 1'b1;
            m_c      <= 1;
            m_store  <= is_store;
            m_mis    <= m_fault(size, addr);
            m_addr   <= addr;
            m_lat    <= m_fault(size, addr) ? 1 : ((is_store && !size[1]) ? 3 : 2);
            m_we_at  <= m_fault(size, addr) ? 0 : (is_store ? (size[1] ? 1 : 2) : 0);
            m_ldval  <= m_load(ref_mem[addr[11:2]], addr, size, uns);
            m_din    <= m_merge(ref_mem[addr[11:2]], addr, size, wdata);
            if (m_fault(size, addr)) m_badv <= addr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            if (done === 1'b1) n_done++;
            chk("busy", {31'b0, busy}, {31'b0, m_active});
            chk("done", {31'b0, done}, {31'b0, m_active && (m_c == m_lat)});
            chk("exc_adel", {31'b0, exc_adel},
                {31'b0, m_active && (m_c == m_lat) && m_mis && !m_store});
            chk("exc_ades", {31'b0, exc_ades},
                {31'b0, m_active && (m_c == m_lat) && m_mis && m_store});
            chk("dm_we", {31'b0, dm_we}, {31'b0, m_active && (m_c == m_we_at) && !rst});
            chk("rdata", rdata, m_rdata);
            chk("badvaddr", badvaddr, m_badv);
            if (m_active && !m_mis) chk("dm_addr", {20'b0, dm_addr}, {20'b0, m_addr[11:2], 2'b00});
            if (m_active && (m_c == m_we_at) && !rst) chk("dm_din", dm_din, m_din);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (m_active && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (m_active) begin
            n_fail++;
            $display("FAIL timeout: access still active after %0d cycles", n);
        end
    endtask

    task automatic issue(input logic st, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
        req = 1'b1;
        is_store = st;
        size = sz;
        uns = u;
        addr = a;
        wdata = wd;
        @(posedge clk);
        #1;
        req = 1'b0;
        wait_idle();
    endtask

    initial begin
        int d0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        load_mem = 1'b0;
        chk_en = 1'b1;
        chk("reset busy", {31'b0, busy}, 32'h0);
        chk("reset rdata", rdata, 32'h0);
        chk("reset badvaddr", badvaddr, 32'h0);

        issue(1'b0, 2'd0, 1'b0, 32'h013, 32'h0);
        chk("LB 0x013", rdata, 32'hFFFF_FF80);
        issue(1'b0, 2'd0, 1'b1, 32'h013, 32'h0);
        chk("LBU 0x013", rdata, 32'h0000_0080);
        issue(1'b0, 2'd0, 1'b0, 32'h011, 32'h0);
        chk("LB 0x011", rdata, 32'h0000_007F);
        issue(1'b0, 2'd1, 1'b0, 32'h012, 32'h0);
        chk("LH 0x012", rdata, 32'hFFFF_80FF);
        issue(1'b0, 2'd1, 1'b1, 32'h010, 32'h0);
        chk("LHU 0x010", rdata, 32'h0000_7F01);

        // Reset lands in the WR cycle of a byte store.
        req = 1'b1; is_store = 1'b1; size = 2'd0; uns = 1'b0; addr = 32'h021; wdata = 32'hAB;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst in WR busy", {31'b0, busy}, 32'h0);
        chk("rst in WR done", {31'b0, done}, 32'h0);
        chk("rst in WR mem", mem[8], 32'h1122_3344);

        issue(1'b1, 2'd0, 1'b0, 32'h021, 32'h0000_00AB);
        chk("SB 0x021 mem", mem[8], 32'h1122_AB44);
        issue(1'b1, 2'd1, 1'b0, 32'h022, 32'h0000_BEEF);
        chk("SH 0x022 mem", mem[8], 32'hBEEF_AB44);
        issue(1'b1, 2'd2, 1'b0, 32'h030, 32'hDEAD_BEEF);
        chk("SW 0x030 mem", mem[12], 32'hDEAD_BEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h030, 32'h0);
        chk("LW 0x030", rdata, 32'hDEAD_BEEF);

        issue(1'b0, 2'd2, 1'b0, 32'h005, 32'h0);
        chk("LW 0x005 rdata kept", rdata, 32'hDEAD_BEEF);
        chk("LW 0x005 badvaddr", badvaddr, 32'h0000_0005);
        issue(1'b1, 2'd1, 1'b0, 32'h007, 32'h0000_1234);
        chk("SH 0x007 mem", mem[1], 32'h0);
        chk("SH 0x007 badvaddr", badvaddr, 32'h0000_0007);
        issue(1'b0, 2'd1, 1'b0, 32'h001, 32'h0);
        chk("LH 0x001 badvaddr", badvaddr, 32'h0000_0001);

        // req held across seven edges: accepts at edges 1, 4 and 7 only.
        d0 = n_done;
        req = 1'b1; is_store = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h010; wdata = 32'h0;
        repeat (7) @(posedge clk);
        #1;
        req = 1'b0;
        wait_idle();
        chk("held req done count", n_done - d0, 32'd3);
        chk("held req rdata", rdata, 32'h80FF_7F01);

        issue(1'b0, 2'd3, 1'b0, 32'h030, 32'h0);
        chk("reserved size load", rdata, 32'hDEAD_BEEF);

        issue(1'b0, 2'd2, 1'b0, 32'h0000_1010, 32'h0);
`ifdef MAU_RANGE_CHK_EN
        chk("range fault badvaddr", badvaddr, 32'h0000_1010);
        chk("range fault rdata kept", rdata, 32'hDEAD_BEEF);
`else
        chk("address wrap load", rdata, 32'h80FF_7F01);
`endif

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
